modbram_writer: RTL and testbench

- Write-side counterpart of the modulus-constant BRAM reader.
- Takes a 256-bit constant and a 5-bit type index, splits the constant into four 64-bit words, and writes them into a 7-series 36Kb SDP BRAM (72-bit port) at addresses {ADDR_HI, type, word_idx}.
- The 72-bit word layout matches the reader's unpacking; word 0 holds bits 63:0.
- Optionally reads the four words back and compares them, reporting per-word mismatches, so constants can be loaded at run time instead of through INIT_xx.

---
 rtl/modbram_writer.sv | 205 ++++++++++++++++++++
 tb/tb_modbram_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbram_writer.sv
// modbram_writer
//   Loads one 256-bit modulus constant into a 7-series 36Kb SDP BRAM
//   (72-bit port) as four 64-bit words at {ADDR_HI, type, word_idx}.
//   Word 0 holds bits 63:0. Byte i of a word sits at di[9i+7:9i], and its
//   parity bit sits at di[9i+8]. With VERIFY_EN set, the four words are
//   read back and compared, and any mismatch is reported per word.
//
// Ports
//   clk       clock; also drives BRAM WRCLK/RDCLK
//   RST       synchronous, active-high reset
//   start     request pulse; only accepted in IDLE
//   type_idx  constant index (0..31); latched on accept
//   wdata     256-bit constant; latched on accept
//   busy      high from accept through the done cycle
//   done      one-cycle completion pulse
//   err       any verify mismatch; valid with done, held until next accept
//   err_word  per-word mismatch mask (bit k = word k)
//   wr_en     BRAM WREN
//   wr_we     BRAM WE (8'hFF while writing)
//   wr_addr   BRAM WRADDR
//   wr_di     BRAM DI
//   rd_en     BRAM RDEN
//   rd_addr   BRAM RDADDR
//   rd_do     BRAM DO (DO_REG=0, valid the cycle after RDEN)
module modbram_writer #(
  parameter logic [1:0] ADDR_HI   = 2'b00,
  parameter bit         VERIFY_EN = 1'b1,
  parameter bit         PARITY_EN = 1'b0
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         start,
  input  logic [4:0]   type_idx,
  input  logic [255:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   err_word,
  output logic         wr_en,
  output logic [7:0]   wr_we,
  output logic [8:0]   wr_addr,
  output logic [71:0]  wr_di,
  output logic         rd_en,
  output logic [8:0]   rd_addr,
  input  logic [71:0]  rd_do
);

  typedef enum logic [3:0] {
    IDLE,
    WR0, WR1, WR2, WR3,
    RD0, RD1, RD2, RD3,
    WT0, WT1, WT2, WT3,
    DONE
  } state_t;

  state_t state, next_state;

  logic [4:0]       type_q;
  logic [3:0][63:0] word_q;

  logic [4:0]       type_cur;
  logic [3:0][63:0] word_cur;
  logic             nxt_wr;
  logic             nxt_rd;
  logic [1:0]       nxt_idx;
  logic [8:0]       nxt_addr;
  logic             chk_valid;
  logic [1:0]       chk_idx;
  logic             chk_bad;
  logic [3:0]       nxt_err_word;

  function automatic logic [71:0] pack_word(input logic [63:0] w);
    logic [71:0] d;
    d = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[9*i +: 8] = w[8*i +: 8];
      d[9*i + 8]  = PARITY_EN ? ^w[8*i +: 8] : 1'b0;
    end
    return d;
  endfunction

  function automatic logic [63:0] unpack_word(input logic [71:0] d);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w[8*i +: 8] = d[9*i +: 8];
    end
    return w;
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WR0;
      WR0:     next_state = WR1;
      WR1:     next_state = WR2;
      WR2:     next_state = WR3;
      WR3:     next_state = VERIFY_EN ? RD0 : DONE;
      RD0:     next_state = WT0;
      WT0:     next_state = RD1;
      RD1:     next_state = WT1;
      WT1:     next_state = RD2;
      RD2:     next_state = WT2;
      WT2:     next_state = RD3;
      RD3:     next_state = WT3;
      WT3:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the request fields are
  // taken straight from the inputs on the accept edge and from the latched
  // copies afterwards.
  always_comb begin
    type_cur = (state == IDLE) ? type_idx : type_q;
    word_cur = (state == IDLE) ? wdata : word_q;

    nxt_wr  = 1'b0;
    nxt_rd  = 1'b0;
    nxt_idx = '0;
    case (next_state)
      WR0: begin nxt_wr = 1'b1; nxt_idx = 2'd0; end
      WR1: begin nxt_wr = 1'b1; nxt_idx = 2'd1; end
      WR2: begin nxt_wr = 1'b1; nxt_idx = 2'd2; end
      WR3: begin nxt_wr = 1'b1; nxt_idx = 2'd3; end
      RD0: begin nxt_rd = 1'b1; nxt_idx = 2'd0; end
      RD1: begin nxt_rd = 1'b1; nxt_idx = 2'd1; end
      RD2: begin nxt_rd = 1'b1; nxt_idx = 2'd2; end
      RD3: begin nxt_rd = 1'b1; nxt_idx = 2'd3; end
      default: ;
    endcase
    nxt_addr = {ADDR_HI, type_cur, nxt_idx};

    chk_valid = 1'b0;
    chk_idx   = '0;
    case (state)
      WT0: begin chk_valid = 1'b1; chk_idx = 2'd0; end
      WT1: begin chk_valid = 1'b1; chk_idx = 2'd1; end
      WT2: begin chk_valid = 1'b1; chk_idx = 2'd2; end
      WT3: begin chk_valid = 1'b1; chk_idx = 2'd3; end
      default: ;
    endcase

    // Parity bits take part in the compare only when they are being driven.
    if (PARITY_EN) begin
      chk_bad = (rd_do != pack_word(word_q[chk_idx]));
    end else begin
      chk_bad = (unpack_word(rd_do) != word_q[chk_idx]);
    end

    nxt_err_word = err_word;
    if (chk_valid && chk_bad) begin
      nxt_err_word[chk_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      type_q   <= '0;
      word_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_word <= '0;
      wr_en    <= 1'b0;
      wr_we    <= '0;
      wr_addr  <= '0;
      wr_di    <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      wr_en <= nxt_wr;
      wr_we <= {8{nxt_wr}};
      rd_en <= nxt_rd;

      if (nxt_wr) begin
        wr_addr <= nxt_addr;
        wr_di   <= pack_word(word_cur[nxt_idx]);
      end
      if (nxt_rd) begin
        rd_addr <= nxt_addr;
      end

      if (state == IDLE && start) begin
        type_q   <= type_idx;
        word_q   <= wdata;
        err      <= 1'b0;
        err_word <= '0;
      end else begin
        if (chk_valid) begin
          err_word <= nxt_err_word;
        end
        if (next_state == DONE) begin
          err <= |nxt_err_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_modbram_writer.sv
// tb_modbram_writer
//   Three writer instances share one clock and reset:
//     0: VERIFY_EN=1, PARITY_EN=0, ADDR_HI=00
//     1: VERIFY_EN=0, PARITY_EN=1, ADDR_HI=00
//     2: VERIFY_EN=1, PARITY_EN=1, ADDR_HI=10
//   Each has a behavioural SDP BRAM (DO_REG=0) with an optional stuck-at-1
//   mask on readback. Expected writes, reads and done pulses are queued when
//   a request is issued and compared as the DUTs produce them.
module tb_modbram_writer;

  localparam logic [2:0] VER = 3'b101;
  localparam logic [2:0] PAR = 3'b110;
  localparam logic [5:0] HI  = {2'b10, 2'b00, 2'b00};

  typedef struct {
    int          id;
    logic [8:0]  addr;
    logic [71:0] di;
    int          cyc;
  } acc_t;

  typedef struct {
    int         id;
    logic       err;
    logic [3:0] ew;
    int         cyc;
  } done_t;

  logic         clk = 1'b0;
  logic         RST;
  logic         start [3];
  logic [4:0]   type_s;
  logic [255:0] wdata_s;
  logic         busy [3];
  logic         done [3];
  logic         err [3];
  logic [3:0]   err_word [3];
  logic         wr_en [3];
  logic [7:0]   wr_we [3];
  logic [8:0]   wr_addr [3];
  logic [71:0]  wr_di [3];
  logic         rd_en [3];
  logic [8:0]   rd_addr [3];
  logic [71:0]  rd_do [3];

  logic [71:0]  mem [3][512];
  logic         fault_on [3];
  logic [8:0]   fault_addr [3];
  logic [71:0]  fault_mask [3];

  acc_t  q_wr [$];
  acc_t  q_rd [$];
  done_t q_done [$];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modbram_writer #(.ADDR_HI(2'b00), .VERIFY_EN(1'b1), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .RST(RST), .start(start[0]), .type_idx(type_s), .wdata(wdata_s),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .err_word(err_word[0]),
    .wr_en(wr_en[0]), .wr_we(wr_we[0]), .wr_addr(wr_addr[0]), .wr_di(wr_di[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_do(rd_do[0]));

  modbram_writer #(.ADDR_HI(2'b00), .VERIFY_EN(1'b0), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .RST(RST), .start(start[1]), .type_idx(type_s), .wdata(wdata_s),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .err_word(err_word[1]),
    .wr_en(wr_en[1]), .wr_we(wr_we[1]), .wr_addr(wr_addr[1]), .wr_di(wr_di[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_do(rd_do[1]));

  modbram_writer #(.ADDR_HI(2'b10), .VERIFY_EN(1'b1), .PARITY_EN(1'b1)) dut_c (
    .clk(clk), .RST(RST), .start(start[2]), .type_idx(type_s), .wdata(wdata_s),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .err_word(err_word[2]),
    .wr_en(wr_en[2]), .wr_we(wr_we[2]), .wr_addr(wr_addr[2]), .wr_di(wr_di[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_do(rd_do[2]));

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Bytes are inserted at the top and shifted down, so byte 0 ends lowest.
  function automatic logic [71:0] pack(input logic [63:0] w, input logic par);
    logic [71:0] r;
    logic [7:0]  b;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b = w[8*i +: 8];
      r = {(par ? ^b : 1'b0), b, r[71:9]};
    end
    return r;
  endfunction

  function automatic logic [63:0] unpack(input logic [71:0] d);
    logic [63:0] w;
    for (int unsigned i = 0; i < 8; i++) w[8*i +: 8] = d[9*i +: 8];
    return w;
  endfunction

  function automatic logic [7:0] par_bits(input logic [71:0] d);
    logic [7:0] p;
    for (int unsigned i = 0; i < 8; i++) p[i] = d[9*i + 8];
    return p;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int unsigned i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural BRAM: synchronous write, synchronous read, DO_REG=0.
  always @(posedge clk) begin
    for (int unsigned d = 0; d < 3; d++) begin
      if (wr_en[d] && wr_we[d] == 8'hFF) mem[d][wr_addr[d]] <= wr_di[d];
      if (rd_en[d]) begin
        rd_do[d] <= mem[d][rd_addr[d]] |
                    ((fault_on[d] && rd_addr[d] == fault_addr[d]) ? fault_mask[d] : 72'h0);
      end
    end
  end

  // Monitors sample on the falling edge, before any stimulus at that edge.
  always @(negedge clk) begin
    acc_t  e;
    done_t de;
    if (!RST) begin
      check("b_rd_en_low", 72'(rd_en[1]), 72'(0));
      for (int unsigned d = 0; d < 3; d++) begin
        check("wr_rd_exclusive", 72'(wr_en[d] & rd_en[d]), 72'(0));
        if (wr_en[d]) begin
          if (q_wr.size() == 0) check("wr_unexpected", 72'(wr_en[d]), 72'(0));
          else begin
            e = q_wr.pop_front();
            check("wr_dut", 72'(d), 72'(e.id));
            check("wr_cycle", 72'(cyc), 72'(e.cyc));
            check("wr_addr", 72'(wr_addr[d]), 72'(e.addr));
            check("wr_di", wr_di[d], e.di);
            check("wr_we", 72'(wr_we[d]), 72'(8'hFF));
          end
        end else if (wr_we[d] != 8'h00) begin
          check("wr_we_idle", 72'(wr_we[d]), 72'(0));
        end
        if (rd_en[d]) begin
          if (q_rd.size() == 0) check("rd_unexpected", 72'(rd_en[d]), 72'(0));
          else begin
            e = q_rd.pop_front();
            check("rd_dut", 72'(d), 72'(e.id));
            check("rd_cycle", 72'(cyc), 72'(e.cyc));
            check("rd_addr", 72'(rd_addr[d]), 72'(e.addr));
          end
        end
        if (done[d]) begin
          if (q_done.size() == 0) check("done_unexpected", 72'(done[d]), 72'(0));
          else begin
            de = q_done.pop_front();
            check("done_dut", 72'(d), 72'(de.id));
            check("done_cycle", 72'(cyc), 72'(de.cyc));
            check("err", 72'(err[d]), 72'(de.err));
            check("err_word", 72'(err_word[d]), 72'(de.ew));
            check("busy_at_done", 72'(busy[d]), 72'(1));
          end
        end
      end
    end
  end

  // Issue a request on instance d in cycle 0; returns in cycle 1.
  task automatic issue(input int d, input logic [4:0] t, input logic [255:0] data,
                       input logic [3:0] exp_ew);
    int n;
    acc_t e;
    done_t de;
    n = cyc;
    for (int unsigned k = 0; k < 4; k++) begin
      e.id = d;
      e.addr = {HI[2*d +: 2], t, 2'(k)};
      e.di = pack(data[64*k +: 64], PAR[d]);
      e.cyc = n + 1 + int'(k);
      q_wr.push_back(e);
      if (VER[d]) begin
        e.cyc = n + 5 + 2 * int'(k);
        q_rd.push_back(e);
      end
    end
    de.id = d;
    de.err = |exp_ew;
    de.ew = exp_ew;
    de.cyc = VER[d] ? n + 13 : n + 5;
    q_done.push_back(de);
    type_s = t;
    wdata_s = data;
    start[d] = 1'b1;
    @(negedge clk); #1;
    start[d] = 1'b0;
    check("accept_busy", 72'(busy[d]), 72'(1));
    check("accept_err_clr", 72'(err[d]), 72'(0));
    check("accept_errw_clr", 72'(err_word[d]), 72'(0));
    // Later changes of the request fields must not leak into the operation.
    type_s = ~t;
    wdata_s = ~data;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q_wr.size() + q_rd.size() + q_done.size()) != 0 && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    check("drain", 72'(q_wr.size() + q_rd.size() + q_done.size()), 72'(0));
    @(negedge clk); #1;
  endtask

  initial begin
    logic [255:0] da, dold, dnew;
    RST = 1'b1;
    type_s = '0;
    wdata_s = '0;
    for (int unsigned d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      fault_on[d] = 1'b0;
      fault_addr[d] = '0;
      fault_mask[d] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int unsigned d = 0; d < 3; d++) begin
      check("rst_busy", 72'(busy[d]), 72'(0));
      check("rst_done", 72'(done[d]), 72'(0));
      check("rst_err", 72'(err[d]), 72'(0));
      check("rst_err_word", 72'(err_word[d]), 72'(0));
      check("rst_wr_en", 72'(wr_en[d]), 72'(0));
      check("rst_wr_we", 72'(wr_we[d]), 72'(0));
      check("rst_wr_addr", 72'(wr_addr[d]), 72'(0));
      check("rst_wr_di", wr_di[d], 72'(0));
      check("rst_rd_en", 72'(rd_en[d]), 72'(0));
      check("rst_rd_addr", 72'(rd_addr[d]), 72'(0));
    end
    RST = 1'b0;
    @(negedge clk); #1;

    // Basic write + verify, then read the entry back like the reader does.
    da = {{3{64'hAAAA_AAAA_AAAA_AAAA}}, 64'hBBBB_BBBB_BBBB_BBBB};
    issue(0, 5'd0, da, 4'b0000);
    drain();
    for (int unsigned k = 0; k < 4; k++)
      check("reader_word", 72'(unpack(mem[0][9'(k)])), 72'(da[64*k +: 64]));
    check("a_parity_zero", 72'(par_bits(mem[0][0])), 72'(0));

    // Stuck-at-1 on bit 9 at 0x02A; word 2 byte 1 is zero.
    da = rnd256();
    da[128 + 8 +: 8] = 8'h00;
    fault_on[0] = 1'b1; fault_addr[0] = 9'h02A; fault_mask[0] = 72'h200;
    issue(0, 5'd10, da, 4'b0100);
    drain();
    repeat (3) @(negedge clk);
    #1;
    check("err_held", 72'(err[0]), 72'(1));
    check("err_word_held", 72'(err_word[0]), 72'(4'b0100));

    // A parity-bit fault is ignored when parity is disabled; accept clears err.
    da = rnd256();
    da[64 +: 8] = 8'h00;
    fault_addr[0] = 9'h031; fault_mask[0] = 72'h100;
    issue(0, 5'd12, da, 4'b0000);
    drain();
    fault_on[0] = 1'b0;

    // Starts during cycle 3 and the DONE cycle are ignored; cycle 14 is taken.
    issue(0, 5'd2, rnd256(), 4'b0000);
    repeat (2) @(negedge clk);
    #1 start[0] = 1'b1;
    @(negedge clk); #1 start[0] = 1'b0;
    repeat (9) @(negedge clk);
    #1 start[0] = 1'b1;
    @(negedge clk); #1;
    issue(0, 5'd4, rnd256(), 4'b0000);
    drain();

    // Reset taking effect where WR2 would start leaves words 2-3 untouched.
    dold = rnd256();
    dnew = rnd256();
    issue(0, 5'd3, dold, 4'b0000);
    drain();
    issue(0, 5'd3, dnew, 4'b0000);
    @(negedge clk); #1;
    RST = 1'b1;
    q_wr.delete();
    q_rd.delete();
    q_done.delete();
    @(negedge clk); #1;
    RST = 1'b0;
    check("midrst_wr_en", 72'(wr_en[0]), 72'(0));
    check("midrst_busy", 72'(busy[0]), 72'(0));
    check("midrst_done", 72'(done[0]), 72'(0));
    repeat (16) @(negedge clk);
    #1;
    check("midrst_w0_new", mem[0][9'h00C], pack(dnew[63:0], 1'b0));
    check("midrst_w1_new", mem[0][9'h00D], pack(dnew[127:64], 1'b0));
    check("midrst_w2_old", mem[0][9'h00E], pack(dold[191:128], 1'b0));
    check("midrst_w3_old", mem[0][9'h00F], pack(dold[255:192], 1'b0));
    issue(0, 5'd3, dnew, 4'b0000);
    drain();

    // Parity generation, write-only instance.
    da = rnd256();
    da[63:0] = 64'h0100_0000_0000_0003;
    issue(1, 5'd5, da, 4'b0000);
    drain();
    check("par_bits_word0", 72'(par_bits(mem[1][9'h014])), 72'(8'h80));

    // Top entry, write-only: 0x07C..0x07F and done in cycle 5.
    issue(1, 5'd31, rnd256(), 4'b0000);
    drain();

    // Parity compare with ADDR_HI=10: clean pass, then a parity-bit fault.
    issue(2, 5'd7, rnd256(), 4'b0000);
    drain();
    da = rnd256();
    da[192 +: 8] = 8'h00;
    fault_on[2] = 1'b1; fault_addr[2] = {2'b10, 5'd7, 2'd3}; fault_mask[2] = 72'h100;
    issue(2, 5'd7, da, 4'b1000);
    drain();
    fault_on[2] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
